// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, FSM state type and helpers for the binary-to-BCD converter.
package bcd_pkg;
    localparam int BCD_DIGIT_W = 4;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to a BCD digit that is 5 or more.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);
    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-add-3 binary to packed BCD converter with a held result register.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          overflow
);
    localparam int SW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    state_t          r_state, w_next;
    logic [BIN_W-1:0] r_shift;
    logic [SW-1:0]    r_scratch, r_bcd, w_adj;
    logic [CW-1:0]    r_cnt;
    logic             r_acc, r_ovf, r_busy, r_done;
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit(r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit(w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE)  ? (start ? SHIFT : IDLE) :
                 (r_state == SHIFT) ? ((r_cnt == CW'(1)) ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_acc     <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (r_state == SHIFT);
            r_done  <= (r_state == DONE);
            if (r_state == IDLE && start) begin
                r_shift   <= bin_in;
                r_scratch <= '0;
                r_acc     <= 1'b0;
                r_cnt     <= CW'(BIN_W);
            end
            // The bit leaving the top digit is a multiple of 10**DIGITS, so it only marks overflow.
            if (r_state == SHIFT) begin
                r_scratch <= {w_adj[SW-2:0], r_shift[BIN_W-1]};
                r_shift   <= r_shift << 1;
                r_acc     <= r_acc | w_adj[SW-1];
                r_cnt     <= r_cnt - CW'(1);
            end
            if (r_state == DONE) begin
                r_bcd <= r_scratch;
                r_ovf <= r_acc;
            end
        end
    end
    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd_out  = r_bcd;
    assign overflow = r_ovf;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for two converters (3 and 2 digits) sharing one stimulus stream.
module tb_bin_to_bcd_seq;
    import bcd_pkg::*;
    typedef struct {logic [11:0] b; logic o;} exp_t;
    logic        clk = 1'b0, rst_n, start;
    logic [7:0]  bin_in;
    logic        busy3, done3, ovf3, busy2, done2, ovf2;
    logic [11:0] bcd3, last3;
    logic [7:0]  bcd2, last2;
    exp_t        q3[$], q2[$];
    int          n_vec = 0, n_err = 0, rst_cyc = 0, busy_run = 0;
    logic        prev_busy = 1'b0;
    always #5 clk = ~clk;
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3));
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2));
    function automatic exp_t ref_model(input int v, input int d);
        exp_t e;
        e.b = '0;
        for (int k = 0; k < d; k++) e.b = e.b | 12'((v / pow10(k)) % 10) << (4 * k);
        e.o = (v >= int'(pow10(d)));
        return e;
    endfunction
    function automatic bit digits_ok(input logic [11:0] b);
        for (int k = 0; k < 3; k++) if (((b >> (4 * k)) & 12'hF) > 12'd9) return 1'b0;
        return 1'b1;
    endfunction
    task automatic push(input int v);
        q3.push_back(ref_model(v, 3));
        q2.push_back(ref_model(v, 2));
    endtask
    task automatic wait_done();
        int n;
        n = 0;
        while (!done3 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done3) begin
            $display("FAIL timeout: done not seen within %0d cycles", n);
            $fatal(1);
        end
    endtask
    task automatic convert(input int v, input bit chk);
        bin_in = 8'(v);
        start  = 1'b1;
        if (chk) push(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
    endtask
    always @(negedge clk) begin
        exp_t e3, e2;
        if (!rst_n) begin
            rst_cyc++;
            busy_run = 0;
            if (rst_cyc >= 2) begin
                n_vec++;
                if ({busy3, done3, bcd3, ovf3, busy2, done2, bcd2, ovf2} !== '0) begin
                    n_err++;
                    $display("FAIL reset: busy=%b done=%b bcd3=%h ovf3=%b bcd2=%h ovf2=%b, want all 0",
                             busy3, done3, bcd3, ovf3, bcd2, ovf2);
                end
            end
            last3 = bcd3;
            last2 = bcd2;
        end else begin
            rst_cyc = 0;
            if (done3 || done2) begin
                n_vec++;
                if (q3.size() == 0 || q2.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: done3=%b done2=%b with no pending request", done3, done2);
                end else begin
                    e3 = q3.pop_front();
                    e2 = q2.pop_front();
                    if (!(done3 && done2) || bcd3 !== e3.b || ovf3 !== e3.o ||
                        {4'h0, bcd2} !== e2.b || ovf2 !== e2.o || !digits_ok(bcd3) || !digits_ok({4'h0, bcd2})) begin
                        n_err++;
                        $display("FAIL result: bcd3=%h ovf3=%b bcd2=%h ovf2=%b done=%b%b, want bcd3=%h ovf3=%b bcd2=%h ovf2=%b",
                                 bcd3, ovf3, bcd2, ovf2, done3, done2, e3.b, e3.o, e2.b[7:0], e2.o);
                    end
                end
                n_vec++;
                if (busy_run != 8 || !prev_busy) begin
                    n_err++;
                    $display("FAIL latency: busy cycles=%0d busy_before_done=%b, want 8 and 1", busy_run, prev_busy);
                end
                busy_run = 0;
                last3 = bcd3;
                last2 = bcd2;
            end else begin
                if (busy3) busy_run++;
                if (busy2 !== busy3 || bcd3 !== last3 || bcd2 !== last2) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL hold: bcd3=%h bcd2=%h busy=%b%b, want bcd3=%h bcd2=%h busy equal",
                             bcd3, bcd2, busy3, busy2, last3, last2);
                end
            end
        end
        prev_busy = busy3;
    end
    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        convert(255, 1);
        for (int i = 0; i < 256; i++) convert(i, 1);
        for (int i = 0; i < 40; i++) convert(int'($urandom_range(0, 255)), 1);
        bin_in = 8'd37;
        start  = 1'b1;
        push(37);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bin_in = 8'd99;
        wait_done();
        push(99);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        bin_in = 8'd200;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        convert(7, 1);
        convert(100, 1);
        convert(99, 1);
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
